// File: rtl/qspi_mem_target.sv
// QSPI memory target: quad-lane read (0xEB) / write (0x38) with a 24-bit address, bridged to a
// single-outstanding byte request interface. SCK, CS and data are oversampled in the clk_i domain.
module qspi_mem_target #(
  parameter int unsigned DUMMY = 6,
  parameter int unsigned SYNC  = 2
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        cs_in,
  input  logic        sck_i,
  input  logic [3:0]  sd_i,
  output logic [3:0]  sd_o,
  output logic [3:0]  sd_oen_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [23:0] mem_adr_o,
  output logic [7:0]  mem_wdat_o,
  input  logic [7:0]  mem_rdat_i,
  input  logic        mem_ack_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_SKIP
  } state_e;

  logic [SYNC-1:0]      cs_sync_q, sck_sync_q, flush_q;
  logic [SYNC-1:0][3:0] sd_sync_q;
  logic                 cs_prev_q, sck_prev_q, armed_q;
  logic                 cs_s, sck_s;
  logic [3:0]           sd_s;
  logic                 cs_fall, cs_rise, sck_rise, sck_fall;

  assign cs_s     = cs_sync_q[SYNC-1];
  assign sck_s    = sck_sync_q[SYNC-1];
  assign sd_s     = sd_sync_q[SYNC-1];
  assign cs_fall  = armed_q & cs_prev_q & ~cs_s;
  assign cs_rise  = ~cs_prev_q & cs_s;
  assign sck_rise = ~sck_prev_q & sck_s;
  assign sck_fall = sck_prev_q & ~sck_s;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      cs_sync_q  <= '1;
      sck_sync_q <= '0;
      sd_sync_q  <= '0;
      flush_q    <= '0;
      cs_prev_q  <= 1'b1;
      sck_prev_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      cs_sync_q  <= {cs_sync_q[SYNC-2:0], cs_in};
      sck_sync_q <= {sck_sync_q[SYNC-2:0], sck_i};
      sd_sync_q  <= {sd_sync_q[SYNC-2:0], sd_i};
      flush_q    <= {flush_q[SYNC-2:0], 1'b1};
      cs_prev_q  <= cs_s;
      sck_prev_q <= sck_s;
      // Decode only after CS has been seen high with the reset value flushed out of the synchronizer.
      if (flush_q[SYNC-1] && cs_s) armed_q <= 1'b1;
    end
  end

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d, hold_q, hold_d, sd_q, sd_d, oen_q, oen_d;
  logic        rd_q, rd_d;
  logic [23:0] adr_q, adr_d;
  // In-flight request, plus a one-entry slot holding the next request until the bus is free.
  logic        req_q, req_d, we_q, we_d, stale_q, stale_d;
  logic [23:0] madr_q, madr_d, sadr_q, sadr_d;
  logic [7:0]  wdat_q, wdat_d, swdat_q, swdat_d;
  logic        sv_q, sv_d, swe_q, swe_d;
  logic [7:0]  buf_q, buf_d, rbyte;
  logic        bufv_q, bufv_d;
  logic [23:0] nxt_adr;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q; cnt_d = cnt_q; hold_d = hold_q; rd_d = rd_q; adr_d = adr_q;
    sd_d = sd_q; oen_d = oen_q;
    req_d = req_q; we_d = we_q; madr_d = madr_q; wdat_d = wdat_q; stale_d = stale_q;
    sv_d = sv_q; swe_d = swe_q; sadr_d = sadr_q; swdat_d = swdat_q;
    buf_d = buf_q; bufv_d = bufv_q;
    rbyte = 8'hFF;
    nxt_adr = adr_q + 24'd1;

    if (req_q && mem_ack_i) begin
      req_d = 1'b0;
      if (!we_q && !stale_q) begin
        buf_d  = mem_rdat_i;
        bufv_d = 1'b1;
      end
    end
    if (!req_q && sv_q) begin
      req_d = 1'b1; we_d = swe_q; madr_d = sadr_q; wdat_d = swdat_q;
      stale_d = 1'b0; sv_d = 1'b0;
    end

    if (cs_rise) begin
      state_d = S_IDLE;
      oen_d   = 4'hF;
      stale_d = 1'b1;
      bufv_d  = 1'b0;
      if (!swe_q) sv_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (cs_fall) begin
          state_d = S_CMD;
          cnt_d   = '0;
        end
        S_CMD: if (sck_rise) begin
          if (cnt_q == 4'd0) begin
            hold_d = sd_s;
            cnt_d  = 4'd1;
          end else begin
            cnt_d = '0;
            case ({hold_q, sd_s})
              8'hEB:   begin state_d = S_ADDR; rd_d = 1'b1; end
              8'h38:   begin state_d = S_ADDR; rd_d = 1'b0; end
              default: state_d = S_SKIP;
            endcase
          end
        end
        S_ADDR: if (sck_rise) begin
          adr_d = {adr_q[19:0], sd_s};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd5) begin
            cnt_d   = '0;
            state_d = rd_q ? S_DUMMY : S_WDATA;
            if (rd_q) begin
              bufv_d = 1'b0;
              if (!(sv_d && swe_d)) begin
                sv_d = 1'b1; swe_d = 1'b0; sadr_d = {adr_q[19:0], sd_s};
              end
            end
          end
        end
        S_DUMMY, S_RDATA: begin
          if (state_q == S_DUMMY && sck_rise) cnt_d = cnt_q + 4'd1;
          if (sck_fall && state_q == S_RDATA && !cnt_q[0]) begin
            sd_d  = hold_q;
            cnt_d = 4'd1;
          end else if (sck_fall && (state_q == S_RDATA || cnt_q == 4'(DUMMY))) begin
            // High-nibble launch: consume the buffered byte (or 0xFF on a miss) and prefetch the next.
            state_d = S_RDATA;
            oen_d   = 4'h0;
            cnt_d   = '0;
            if (bufv_d) rbyte = buf_d;
            sd_d    = rbyte[7:4];
            hold_d  = rbyte[3:0];
            bufv_d  = 1'b0;
            adr_d   = nxt_adr;
            if (req_d && !we_d) stale_d = 1'b1;
            if (!(sv_d && swe_d)) begin
              sv_d = 1'b1; swe_d = 1'b0; sadr_d = nxt_adr;
            end
          end
        end
        S_WDATA: if (sck_rise) begin
          if (!cnt_q[0]) begin
            hold_d = sd_s;
            cnt_d  = 4'd1;
          end else begin
            cnt_d = '0;
            adr_d = nxt_adr;
            if (!sv_d && !(req_d && we_d)) begin
              sv_d = 1'b1; swe_d = 1'b1; sadr_d = adr_q; swdat_d = {hold_q, sd_s};
            end
          end
        end
        S_SKIP: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE; cnt_q <= '0; hold_q <= '0; rd_q <= 1'b0; adr_q <= '0;
      sd_q <= 4'h0; oen_q <= 4'hF;
      req_q <= 1'b0; we_q <= 1'b0; madr_q <= '0; wdat_q <= '0; stale_q <= 1'b0;
      sv_q <= 1'b0; swe_q <= 1'b0; sadr_q <= '0; swdat_q <= '0;
      buf_q <= '0; bufv_q <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; hold_q <= hold_d; rd_q <= rd_d; adr_q <= adr_d;
      sd_q <= sd_d; oen_q <= oen_d;
      req_q <= req_d; we_q <= we_d; madr_q <= madr_d; wdat_q <= wdat_d; stale_q <= stale_d;
      sv_q <= sv_d; swe_q <= swe_d; sadr_q <= sadr_d; swdat_q <= swdat_d;
      buf_q <= buf_d; bufv_q <= bufv_d;
    end
  end

  assign sd_o       = sd_q;
  assign sd_oen_o   = oen_q;
  assign mem_req_o  = req_q;
  assign mem_we_o   = we_q;
  assign mem_adr_o  = madr_q;
  assign mem_wdat_o = wdat_q;

endmodule

// File: tb/tb_qspi_mem_target.sv
// Bench for qspi_mem_target: directed QSPI transactions; expected memory requests and read
// nibbles are queued up front and matched by independent monitors against a responding memory.
module tb_qspi_mem_target;

  localparam int HALF  = 8;
  localparam int DUMMY = 6;

  logic        clk_i = 1'b0, rst_in = 1'b0, cs_in = 1'b1, sck_i = 1'b0;
  logic [3:0]  sd_i = 4'h0;
  logic [3:0]  sd_o, sd_oen_o;
  logic        mem_req_o, mem_we_o;
  logic [23:0] mem_adr_o;
  logic [7:0]  mem_wdat_o;
  logic [7:0]  mem_rdat_i = 8'h00;
  logic        mem_ack_i = 1'b0;

  always #5 clk_i = ~clk_i;

  qspi_mem_target #(.DUMMY(DUMMY), .SYNC(2)) dut (
    .clk_i(clk_i), .rst_in(rst_in), .cs_in(cs_in), .sck_i(sck_i), .sd_i(sd_i),
    .sd_o(sd_o), .sd_oen_o(sd_oen_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o),
    .mem_wdat_o(mem_wdat_o), .mem_rdat_i(mem_rdat_i), .mem_ack_i(mem_ack_i)
  );

  typedef struct packed {
    logic        we;
    logic [23:0] adr;
    logic [7:0]  wdat;
  } mreq_t;

  mreq_t       exp_mem[$];
  logic [3:0]  exp_nib[$];
  logic [7:0]  mem [logic [23:0]];
  int          n_checks = 0, n_fail = 0;
  logic        stall_en = 1'b0;
  logic [23:0] stall_adr = '0;
  int          stall_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected value %0h", name, act);
  endtask

  // Memory responder: acks after 2 cycles, or after stall_len cycles for the selected read address.
  int   resp_dly;
  initial forever begin
    @(negedge clk_i);
    if (mem_req_o && rst_in) begin
      resp_dly = 2;
      if (stall_en && !mem_we_o && mem_adr_o == stall_adr) begin
        resp_dly = stall_len;
        stall_en = 1'b0;
      end
      repeat (resp_dly - 1) @(negedge clk_i);
      if (mem_req_o) begin
        if (mem_we_o) mem[mem_adr_o] = mem_wdat_o;
        mem_rdat_i = mem.exists(mem_adr_o) ? mem[mem_adr_o] : 8'h00;
        mem_ack_i  = 1'b1;
        @(negedge clk_i);
        mem_ack_i  = 1'b0;
      end
    end
  end

  mreq_t em;
  initial forever begin
    @(negedge clk_i);
    #1;
    if (mem_req_o && mem_ack_i) begin
      if (exp_mem.size() == 0) unexpected("mem_req", {7'd0, mem_we_o, mem_adr_o});
      else begin
        em = exp_mem.pop_front();
        check("mem_we", 32'(mem_we_o), 32'(em.we));
        check("mem_adr", 32'(mem_adr_o), 32'(em.adr));
        if (em.we) check("mem_wdat", 32'(mem_wdat_o), 32'(em.wdat));
      end
    end
  end

  logic [3:0] en;
  always @(posedge sck_i) begin
    if (sd_oen_o == 4'h0) begin
      if (exp_nib.size() == 0) unexpected("sd_drive", 32'(sd_o));
      else begin
        en = exp_nib.pop_front();
        check("sd_nibble", 32'(sd_o), 32'(en));
      end
    end else if (sd_oen_o != 4'hF) begin
      unexpected("sd_oen_partial", 32'(sd_oen_o));
    end
  end

  task automatic sck_cycle(input logic [3:0] nib);
    sd_i = nib;
    repeat (HALF) @(negedge clk_i);
    sck_i = 1'b1;
    repeat (HALF) @(negedge clk_i);
    sck_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    sck_cycle(b[7:4]);
    sck_cycle(b[3:0]);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] adr);
    send_byte(cmd);
    send_byte(adr[23:16]);
    send_byte(adr[15:8]);
    send_byte(adr[7:0]);
  endtask

  task automatic cs_start();
    cs_in = 1'b0;
    repeat (HALF) @(negedge clk_i);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk_i);
    cs_in = 1'b1;
    repeat (3 * HALF) @(negedge clk_i);
  endtask

  task automatic push_mem(input logic we, input logic [23:0] adr, input logic [7:0] wdat);
    mreq_t r;
    r.we = we; r.adr = adr; r.wdat = wdat;
    exp_mem.push_back(r);
  endtask

  // nibs is MSB-first; only complete bytes are expected as writes.
  task automatic do_write(input logic [23:0] adr, input int nnib, input logic [31:0] nibs);
    cs_start();
    send_hdr(8'h38, adr);
    for (int i = 0; i < nnib; i++) begin
      if (i % 2 == 1) push_mem(1'b1, adr + 24'(i / 2), nibs[35 - 4*i -: 8]);
      sck_cycle(nibs[31 - 4*i -: 4]);
    end
    cs_end();
  endtask

  // data holds the expected bytes MSB-first; the final falling edge prefetches up to adr+n+1.
  task automatic do_read(input logic [23:0] adr, input int n, input logic [31:0] data);
    for (int i = 0; i < n + 2; i++) push_mem(1'b0, adr + 24'(i), 8'h00);
    for (int i = 0; i < n; i++) begin
      exp_nib.push_back(data[31 - 8*i -: 4]);
      exp_nib.push_back(data[27 - 8*i -: 4]);
    end
    cs_start();
    send_hdr(8'hEB, adr);
    repeat (DUMMY) sck_cycle(4'h0);
    for (int i = 0; i < 2 * n; i++) sck_cycle(4'h0);
    cs_end();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"}, 32'(mem_req_o), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we_o), 32'd0);
    check({tag, "_mem_adr"}, 32'(mem_adr_o), 32'd0);
    check({tag, "_mem_wdat"}, 32'(mem_wdat_o), 32'd0);
    check({tag, "_sd_o"}, 32'(sd_o), 32'd0);
    check({tag, "_sd_oen"}, 32'(sd_oen_o), 32'hF);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[24'h000020] = 8'h12; mem[24'h000021] = 8'h34;
    mem[24'hFFFFFF] = 8'h5A; mem[24'h000000] = 8'hC3;
    mem[24'h000030] = 8'hAB; mem[24'h000031] = 8'hCD;
    mem[24'h000032] = 8'hEF; mem[24'h000033] = 8'h01;

    repeat (4) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_in = 1'b1;
    repeat (10) @(negedge clk_i);

    do_write(24'h000010, 4, 32'hA53C_0000);
    do_read(24'h000020, 2, 32'h1234_0000);
    do_read(24'hFFFFFF, 2, 32'h5AC3_0000);

    cs_start();
    send_byte(8'h9F);
    for (int i = 0; i < 20; i++) sck_cycle(4'(i));
    cs_end();
    do_write(24'h000050, 2, 32'h1100_0000);

    do_write(24'h000040, 3, 32'h7E90_0000);
    do_write(24'h000044, 2, 32'h5500_0000);

    stall_adr = 24'h000031; stall_len = 40; stall_en = 1'b1;
    do_read(24'h000030, 4, 32'hABFF_EF01);

    // Reset with a stalled read outstanding and CS held low across the release.
    stall_adr = 24'h000070; stall_len = 60; stall_en = 1'b1;
    cs_start();
    send_hdr(8'hEB, 24'h000070);
    repeat (2) sck_cycle(4'h0);
    rst_in = 1'b0;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("midreset");
    rst_in = 1'b1;
    send_hdr(8'h38, 24'h000080);
    send_byte(8'h12);
    cs_end();
    check("held_low_no_write", 32'(mem.exists(24'h000080)), 32'd0);
    stall_en = 1'b0;
    do_write(24'h000060, 2, 32'h9900_0000);

    repeat (50) @(negedge clk_i);
    check("exp_mem_drained", 32'(exp_mem.size()), 32'd0);
    check("exp_nib_drained", 32'(exp_nib.size()), 32'd0);
    check("final_oen", 32'(sd_oen_o), 32'hF);
    check("final_req", 32'(mem_req_o), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
